// File: rtl/uart_frame_sequencer_if.sv
// Frame/UART bus bundle for uart_frame_sequencer.
// slave = sequencer side, master = SPI front end and uart_tx bank side.
`timescale 1ns/1ps
interface uart_frame_sequencer_if #(
    parameter int NUM_OF_MODULES = 9
);
    logic                      frame_valid;
    logic                      frame_ready;
    logic [11:0]               sin_index;
    logic [3:0]                uart_id;
    logic [NUM_OF_MODULES-1:0] module_en;
    logic [NUM_OF_MODULES-1:0] tx_busy;
    logic [NUM_OF_MODULES-1:0] start_tx;
    logic [7:0]                data_to_tx;
    logic                      frame_done;
    logic                      timeout_err;
    logic [NUM_OF_MODULES-1:0] fail_mask;

    modport slave (
        input  frame_valid,
        input  sin_index,
        input  uart_id,
        input  module_en,
        input  tx_busy,
        output frame_ready,
        output start_tx,
        output data_to_tx,
        output frame_done,
        output timeout_err,
        output fail_mask
    );

    modport master (
        output frame_valid,
        output sin_index,
        output uart_id,
        output module_en,
        output tx_busy,
        input  frame_ready,
        input  start_tx,
        input  data_to_tx,
        input  frame_done,
        input  timeout_err,
        input  fail_mask
    );
endinterface

// File: rtl/uart_frame_sequencer.sv
// Sequences the two-byte sine-index frame to the uart_tx bank.
// Optional FRAME_CHECKSUM_EN appends a third byte (byte1 ^ byte2).
`timescale 1ns/1ps
module uart_frame_sequencer #(
    parameter int NUM_OF_MODULES = 9,
    parameter int TIMEOUT_CYC    = 4096,
    parameter int CNT_W          = 13
) (
    input  logic clk,
    input  logic reset,
    uart_frame_sequencer_if.slave bus
);

    localparam int N = NUM_OF_MODULES;

`ifdef FRAME_CHECKSUM_EN
    localparam int             IDX_W    = 2;
    localparam logic [IDX_W-1:0] LAST_IDX = 2'd2;
`else
    localparam int             IDX_W    = 1;
    localparam logic [IDX_W-1:0] LAST_IDX = 1'b1;
`endif

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_ACK,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       b1_q, b1_d;
    logic [7:0]       b2_q, b2_d;
    logic [7:0]       data_q, data_d;
    logic [N-1:0]     en_q, en_d;
    logic [N-1:0]     ack_q, ack_d;
    logic [N-1:0]     fail_q, fail_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             terr_q, terr_d;

    logic [N-1:0]     start_o;
    logic             ready_o;
    logic             done_o;
    logic             terr_o;
    logic [N-1:0]     ack_now;
    logic [N-1:0]     drain_busy;
    logic             cnt_hit;
    logic [7:0]       next_byte;

    // Byte that follows the one currently on data_to_tx.
    always_comb begin
        next_byte = b2_q;
`ifdef FRAME_CHECKSUM_EN
        if (idx_q != '0) begin
            next_byte = b1_q ^ b2_q;
        end
`endif
    end

    // Phase bookkeeping: sticky ack, busy drain and timeout compare.
    always_comb begin
        ack_now    = ack_q | (bus.tx_busy & en_q);
        drain_busy = bus.tx_busy & en_q;
        cnt_hit    = (cnt_q == CNT_LAST);
    end

    // Next-state and output decode for the frame sequencer.
    always_comb begin
        state_d = state_q;
        b1_d    = b1_q;
        b2_d    = b2_q;
        data_d  = data_q;
        en_d    = en_q;
        ack_d   = ack_q;
        fail_d  = fail_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        terr_d  = terr_q;
        start_o = '0;
        ready_o = 1'b0;
        done_o  = 1'b0;
        terr_o  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                ready_o = 1'b1;
                if (bus.frame_valid) begin
                    b1_d   = {bus.uart_id, bus.sin_index[11:8]};
                    b2_d   = bus.sin_index[7:0];
                    en_d   = bus.module_en;
                    fail_d = '0;
                    terr_d = 1'b0;
                    idx_d  = '0;
                    ack_d  = '0;
                    cnt_d  = '0;
                    if (bus.module_en == '0) begin
                        state_d = S_DONE;
                    end else begin
                        data_d  = {bus.uart_id, bus.sin_index[11:8]};
                        state_d = S_SEND;
                    end
                end
            end
            S_SEND: begin
                start_o = en_q;
                ack_d   = bus.tx_busy & en_q;
                cnt_d   = '0;
                state_d = S_ACK;
            end
            S_ACK: begin
                start_o = en_q & ~ack_q;
                ack_d   = ack_now;
                cnt_d   = cnt_q + 1'b1;
                if (ack_now == en_q) begin
                    state_d = S_DRAIN;
                end else if (cnt_hit) begin
                    fail_d  = fail_q | (en_q & ~ack_now);
                    terr_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DRAIN: begin
                cnt_d = cnt_q + 1'b1;
                if (drain_busy == '0) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        data_d  = next_byte;
                        state_d = S_SEND;
                    end
                end else if (cnt_hit) begin
                    fail_d  = fail_q | drain_busy;
                    terr_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done_o  = 1'b1;
                terr_o  = terr_q;
                terr_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any frame in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            b1_q    <= '0;
            b2_q    <= '0;
            data_q  <= '0;
            en_q    <= '0;
            ack_q   <= '0;
            fail_q  <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            b1_q    <= b1_d;
            b2_q    <= b2_d;
            data_q  <= data_d;
            en_q    <= en_d;
            ack_q   <= ack_d;
            fail_q  <= fail_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            terr_q  <= terr_d;
        end
    end

    assign bus.frame_ready = ready_o;
    assign bus.start_tx    = start_o;
    assign bus.data_to_tx  = data_q;
    assign bus.frame_done  = done_o;
    assign bus.timeout_err = terr_o;
    assign bus.fail_mask   = fail_q;

endmodule
